// File: rtl/cache_ctrl.sv
// Sequencing FSM for a direct-mapped, write-through, read-allocate data cache.
// Ports: clk/rst; CPU mem_read/mem_write/addr; cache valid_out/tag_out;
//  dmem_ack; outputs stall, cache/fill enables, block_indx/word_offset/tag_in,
//  dmem_rd_req/dmem_wr_req, saturating hit_cnt/miss_cnt, sticky err.
module cache_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic              valid_out,
  input  logic [2:0]        tag_out,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              cache_read,
  output logic              fill_from_Dmem,
  output logic              fill_from_DataIn,
  output logic [4:0]        block_indx,
  output logic [1:0]        word_offset,
  output logic [2:0]        tag_in,
  output logic              dmem_rd_req,
  output logic              dmem_wr_req,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE, REFILL, FILL, WRITE
  } state_t;

  localparam int TW = $clog2(TIMEOUT) + 1;
  // Abort when this wait cycle would bring the count to TIMEOUT-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, a_addr;
  logic              hit_q, hit;
  logic [TW-1:0]     tmo;
  logic              tmo_exp;
  logic              latch, hit_inc, miss_inc, abort;

  // Outside IDLE the transaction address is frozen.
  assign a_addr      = (state == IDLE) ? addr : addr_q;
  assign tag_in      = a_addr[ADDR_W-1 -: 3];
  assign block_indx  = a_addr[6:2];
  assign word_offset = a_addr[1:0];
  assign hit         = valid_out && (tag_out == tag_in);
  assign tmo_exp     = (tmo == TMO_LAST);

  always_comb begin
    state_n          = state;
    stall            = 1'b0;
    cache_read       = 1'b0;
    fill_from_Dmem   = 1'b0;
    fill_from_DataIn = 1'b0;
    dmem_rd_req      = 1'b0;
    dmem_wr_req      = 1'b0;
    latch            = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    abort            = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          stall   = 1'b1;
          latch   = 1'b1;
          state_n = WRITE;
        end else if (mem_read) begin
          if (hit) begin
            cache_read = 1'b1;
            hit_inc    = 1'b1;
          end else begin
            stall    = 1'b1;
            latch    = 1'b1;
            miss_inc = 1'b1;
            state_n  = REFILL;
          end
        end
      end
      REFILL: begin
        stall       = 1'b1;
        dmem_rd_req = 1'b1;
        if (dmem_ack) begin
          state_n = FILL;
        end else if (tmo_exp) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      FILL: begin
        stall          = 1'b1;
        fill_from_Dmem = 1'b1;
        state_n        = IDLE;
      end
      WRITE: begin
        dmem_wr_req = 1'b1;
        if (dmem_ack) begin
          // Release the CPU on the ack cycle itself.
          fill_from_DataIn = hit_q;
          state_n          = IDLE;
        end else begin
          stall = 1'b1;
          if (tmo_exp) begin
            abort   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      tmo      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) begin
        addr_q <= addr;
        hit_q  <= hit;
      end
      if (latch)
        tmo <= '0;
      else if (state == REFILL || state == WRITE)
        tmo <= tmo + 1'b1;
      if (hit_inc && !(&hit_cnt))
        hit_cnt <= hit_cnt + 1'b1;
      if (miss_inc && !(&miss_cnt))
        miss_cnt <= miss_cnt + 1'b1;
      if (abort)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table plus timeout, reset,
// stray-ack and counter-saturation sequences.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write;
  logic [9:0]  addr;
  logic        valid_out, dmem_ack;
  logic [2:0]  tag_out;
  logic        stall, cache_read, fill_from_Dmem, fill_from_DataIn;
  logic [4:0]  block_indx;
  logic [1:0]  word_offset;
  logic [2:0]  tag_in;
  logic        dmem_rd_req, dmem_wr_req, err;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_stall, s_cache_read, s_fill_dm, s_fill_di;
  logic [4:0]  s_block_indx;
  logic [1:0]  s_word_offset;
  logic [2:0]  s_tag_in;
  logic        s_rd_req, s_wr_req, s_err;
  logic [3:0]  s_hit_cnt, s_miss_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_W(10), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .valid_out(valid_out), .tag_out(tag_out),
    .dmem_ack(dmem_ack), .stall(stall), .cache_read(cache_read),
    .fill_from_Dmem(fill_from_Dmem), .fill_from_DataIn(fill_from_DataIn),
    .block_indx(block_indx), .word_offset(word_offset), .tag_in(tag_in),
    .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  cache_ctrl #(.ADDR_W(10), .CNT_W(4), .TIMEOUT(8)) dut_s (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .valid_out(valid_out), .tag_out(tag_out),
    .dmem_ack(dmem_ack), .stall(s_stall), .cache_read(s_cache_read),
    .fill_from_Dmem(s_fill_dm), .fill_from_DataIn(s_fill_di),
    .block_indx(s_block_indx), .word_offset(s_word_offset),
    .tag_in(s_tag_in), .dmem_rd_req(s_rd_req), .dmem_wr_req(s_wr_req),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .err(s_err)
  );

  typedef struct {
    logic rst, rd, wr;
    logic [9:0] addr;
    logic vld;
    logic [2:0] tg;
    logic ack;
    logic st, cr, fd, fi;
    logic [4:0] bi;
    logic [1:0] wo;
    logic [2:0] ti;
    logic rq, wq;
    logic [15:0] hc, mc;
    logic er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_req(output int n);
    n = 0;
    @(negedge clk);
    while (dmem_rd_req && n < 40) begin
      n++;
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [48:0] got, sgot, exp;
    int n;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0;
    valid_out = 1'b0; tag_out = '0; dmem_ack = 1'b0;

    // rst rd wr addr vld tg ack | st cr fd fi bi wo ti rq wq hc mc er
    tbl.push_back('{'1,'0,'0,10'h000,'0,3'd0,'0,
      '0,'0,'0,'0,5'd0,2'd0,3'd0,'0,'0,16'd0,16'd0,'0});
    tbl.push_back('{'0,'1,'0,10'h3A5,'0,3'd0,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd7,'0,'0,16'd0,16'd0,'0});
    tbl.push_back('{'0,'1,'0,10'h000,'0,3'd0,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd7,'1,'0,16'd0,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A5,'0,3'd0,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd7,'1,'0,16'd0,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A5,'0,3'd0,'1,
      '1,'0,'0,'0,5'd9,2'd1,3'd7,'1,'0,16'd0,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A5,'0,3'd0,'0,
      '1,'0,'1,'0,5'd9,2'd1,3'd7,'0,'0,16'd0,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A5,'1,3'd7,'0,
      '0,'1,'0,'0,5'd9,2'd1,3'd7,'0,'0,16'd0,16'd1,'0});
    tbl.push_back('{'0,'0,'0,10'h3A5,'1,3'd7,'0,
      '0,'0,'0,'0,5'd9,2'd1,3'd7,'0,'0,16'd1,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A6,'1,3'd7,'0,
      '0,'1,'0,'0,5'd9,2'd2,3'd7,'0,'0,16'd1,16'd1,'0});
    tbl.push_back('{'0,'1,'0,10'h3A7,'1,3'd7,'0,
      '0,'1,'0,'0,5'd9,2'd3,3'd7,'0,'0,16'd2,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd2,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'0,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd2,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd2,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd0,'1,
      '0,'0,'0,'1,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'0,10'h125,'1,3'd2,'0,
      '0,'0,'0,'0,5'd9,2'd1,3'd2,'0,'0,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd5,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'0,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd5,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd5,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'1,10'h125,'1,3'd2,'1,
      '0,'0,'0,'0,5'd9,2'd1,3'd2,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'0,10'h125,'1,3'd5,'0,
      '0,'0,'0,'0,5'd9,2'd1,3'd2,'0,'0,16'd3,16'd1,'0});
    tbl.push_back('{'0,'1,'1,10'h3A5,'1,3'd7,'0,
      '1,'0,'0,'0,5'd9,2'd1,3'd7,'0,'0,16'd3,16'd1,'0});
    tbl.push_back('{'0,'1,'1,10'h3A5,'1,3'd7,'1,
      '0,'0,'0,'1,5'd9,2'd1,3'd7,'0,'1,16'd3,16'd1,'0});
    tbl.push_back('{'0,'0,'0,10'h3A5,'1,3'd7,'0,
      '0,'0,'0,'0,5'd9,2'd1,3'd7,'0,'0,16'd3,16'd1,'0});

    repeat (2) step();

    foreach (tbl[i]) begin
      rst = tbl[i].rst; mem_read = tbl[i].rd; mem_write = tbl[i].wr;
      addr = tbl[i].addr; valid_out = tbl[i].vld;
      tag_out = tbl[i].tg; dmem_ack = tbl[i].ack;
      @(negedge clk);
      exp = {tbl[i].st, tbl[i].cr, tbl[i].fd, tbl[i].fi, tbl[i].bi,
             tbl[i].wo, tbl[i].ti, tbl[i].rq, tbl[i].wq, tbl[i].hc,
             tbl[i].mc, tbl[i].er};
      got = {stall, cache_read, fill_from_Dmem, fill_from_DataIn,
             block_indx, word_offset, tag_in, dmem_rd_req, dmem_wr_req,
             hit_cnt, miss_cnt, err};
      sgot = {s_stall, s_cache_read, s_fill_dm, s_fill_di, s_block_indx,
              s_word_offset, s_tag_in, s_rd_req, s_wr_req,
              12'h0, s_hit_cnt, 12'h0, s_miss_cnt, s_err};
      nvec++;
      if (got !== exp || sgot !== exp) begin
        nerr++;
        $display("FAIL vec%0d: got %h narrow %h want %h", i, got, sgot, exp);
      end
      step();
    end

    // Read miss with no ack: abort after 7 wait cycles, request re-issued.
    mem_read = 1'b1; addr = 10'h000; valid_out = 1'b0; tag_out = 3'd0;
    step();
    count_req(n);
    chk("tmo_wait_cycles", 32'(n), 32'd7);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_idle_rdreq", 32'(dmem_rd_req), 32'd0);
    chk("tmo_reissue_stall", 32'(stall), 32'd1);
    chk("tmo_miss_cnt", 32'(miss_cnt), 32'd2);
    step();
    mem_read = 1'b0;
    count_req(n);
    chk("tmo_restart_cycles", 32'(n), 32'd7);
    chk("tmo2_stall", 32'(stall), 32'd0);
    chk("tmo2_miss_cnt", 32'(miss_cnt), 32'd3);

    // Late ack in IDLE is ignored.
    step();
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_stall", 32'(stall), 32'd0);
    chk("stray_ack_fill", 32'({fill_from_Dmem, fill_from_DataIn}), 32'd0);
    step();
    @(negedge clk);
    chk("stray_ack_req", 32'({dmem_rd_req, dmem_wr_req, stall}), 32'd0);
    chk("stray_ack_err", 32'(err), 32'd1);
    step();
    dmem_ack = 1'b0;

    // Reset in the middle of a refill.
    mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    step();
    @(negedge clk);
    chk("mid_refill_rdreq", 32'(dmem_rd_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdreq", 32'(dmem_rd_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnts", 32'({hit_cnt, miss_cnt}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Back-to-back hits drive the narrow counter to saturation.
    step();
    mem_read = 1'b1; addr = 10'h3A5; valid_out = 1'b1; tag_out = 3'd7;
    repeat (15) step();
    @(negedge clk);
    chk("sat_hit_15", 32'(hit_cnt), 32'd15);
    chk("sat_narrow_full", 32'(s_hit_cnt), 32'hF);
    repeat (5) step();
    @(negedge clk);
    chk("sat_hit_20", 32'(hit_cnt), 32'd20);
    chk("sat_narrow_hold", 32'(s_hit_cnt), 32'hF);
    chk("sat_narrow_miss", 32'(s_miss_cnt), 32'd0);
    mem_read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
